// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one my_bram port between requesters A and B.
// Registers the winning command, returns read data to its issuer, and signals done once traffic drains.
module bram_port_arbiter #(
  parameter int BRAM_ADDR_WIDTH = 15
) (
  input  logic                       BRAM_CLK,
  input  logic                       BRAM_RSTN,
  input  logic                       a_req,
  input  logic [3:0]                 a_we,
  input  logic [BRAM_ADDR_WIDTH-1:0] a_addr,
  input  logic [31:0]                a_wrdata,
  input  logic                       a_done,
  input  logic                       b_req,
  input  logic [3:0]                 b_we,
  input  logic [BRAM_ADDR_WIDTH-1:0] b_addr,
  input  logic [31:0]                b_wrdata,
  input  logic                       b_done,
  output logic                       a_gnt,
  output logic                       b_gnt,
  output logic                       a_rdvalid,
  output logic                       b_rdvalid,
  output logic [31:0]                a_rddata,
  output logic [31:0]                b_rddata,
  output logic [BRAM_ADDR_WIDTH-1:0] BRAM_ADDR,
  output logic [31:0]                BRAM_WRDATA,
  output logic [3:0]                 BRAM_WE,
  output logic                       BRAM_EN,
  output logic                       BRAM_RST,
  input  logic [31:0]                BRAM_RDDATA,
  output logic                       done
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t                     state_q, state_d;
  logic                       last_b_q, last_b_d;
  logic                       a_flag_q, a_flag_d;
  logic                       b_flag_q, b_flag_d;
  logic [2:0]                 pipe_valid_q, pipe_valid_d;
  logic [2:0]                 pipe_id_q, pipe_id_d;
  logic [BRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]                wrdata_q, wrdata_d;
  logic [3:0]                 we_q, we_d;
  logic                       en_q, en_d;
  logic                       rst_q, rst_d;
  logic                       done_q, done_d;
  logic                       issue_rd;

  // last_b_q set means B won the previous accept, so A wins the next tie.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (state_q == ST_RUN) begin
      if (a_req && b_req) begin
        a_gnt = last_b_q;
        b_gnt = !last_b_q;
      end else begin
        a_gnt = a_req;
        b_gnt = b_req;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    last_b_d = last_b_q;
    addr_d   = addr_q;
    wrdata_d = wrdata_q;
    we_d     = 4'b0000;
    en_d     = 1'b1;
    rst_d    = 1'b0;
    a_flag_d = a_flag_q | a_done;
    b_flag_d = b_flag_q | b_done;

    if (a_gnt) begin
      addr_d   = a_addr;
      wrdata_d = a_wrdata;
      we_d     = a_we;
      last_b_d = 1'b0;
    end else if (b_gnt) begin
      addr_d   = b_addr;
      wrdata_d = b_wrdata;
      we_d     = b_we;
      last_b_d = 1'b1;
    end

    // Stage 3 lines up with the BRAM output register two edges after the command is presented.
    issue_rd     = (a_gnt && (a_we == 4'b0000)) || (b_gnt && (b_we == 4'b0000));
    pipe_valid_d = {pipe_valid_q[1:0], issue_rd};
    pipe_id_d    = {pipe_id_q[1:0], b_gnt};

    case (state_q)
      ST_RUN:   if (a_flag_d && b_flag_d) state_d = ST_DRAIN;
      ST_DRAIN: if (pipe_valid_q == 3'b000) state_d = ST_DONE;
      default:  state_d = ST_DONE;
    endcase
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge BRAM_CLK or negedge BRAM_RSTN) begin
    if (!BRAM_RSTN) begin
      state_q      <= ST_RUN;
      last_b_q     <= 1'b1;
      a_flag_q     <= 1'b0;
      b_flag_q     <= 1'b0;
      pipe_valid_q <= 3'b000;
      pipe_id_q    <= 3'b000;
      addr_q       <= '0;
      wrdata_q     <= '0;
      we_q         <= 4'b0000;
      en_q         <= 1'b0;
      rst_q        <= 1'b1;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_b_q     <= last_b_d;
      a_flag_q     <= a_flag_d;
      b_flag_q     <= b_flag_d;
      pipe_valid_q <= pipe_valid_d;
      pipe_id_q    <= pipe_id_d;
      addr_q       <= addr_d;
      wrdata_q     <= wrdata_d;
      we_q         <= we_d;
      en_q         <= en_d;
      rst_q        <= rst_d;
      done_q       <= done_d;
    end
  end

  assign a_rdvalid   = pipe_valid_q[2] & ~pipe_id_q[2];
  assign b_rdvalid   = pipe_valid_q[2] &  pipe_id_q[2];
  assign a_rddata    = BRAM_RDDATA;
  assign b_rddata    = BRAM_RDDATA;
  assign BRAM_ADDR   = addr_q;
  assign BRAM_WRDATA = wrdata_q;
  assign BRAM_WE     = we_q;
  assign BRAM_EN     = en_q;
  assign BRAM_RST    = rst_q;
  assign done        = done_q;

endmodule
